// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB completer: FSM state encoding,
// default bus/memory geometry and the memory index-width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_ADDRESSWIDTH = 32;
    localparam int DEF_DATAWIDTH    = 8;
    localparam int DEF_MEM_DEPTH    = 256;
    localparam int DEF_WAIT_STATES  = 0;

    function automatic int index_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/apb_slave_if.sv
// APB requester/completer signal bundle; clock and reset stay outside.
interface apb_slave_if #(
    parameter int ADDRESSWIDTH = 32,
    parameter int DATAWIDTH    = 8
);
    logic [ADDRESSWIDTH-1:0] PADDR;
    logic [DATAWIDTH-1:0]    PWDATA;
    logic                    PWRITE;
    logic                    PSELx;
    logic                    PENABLE;
    logic [DATAWIDTH-1:0]    PRDATA;
    logic                    PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PSELx, PENABLE,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSELx, PENABLE,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_slave_mem.sv
// Local register memory: one synchronous write port, one combinational read
// port, whole array cleared by the asynchronous reset.
module apb_slave_mem #(
    parameter int DATAWIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter int IW        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IW-1:0]        waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [IW-1:0]        raddr,
    output logic [DATAWIDTH-1:0] rdata
);
    logic [DATAWIDTH-1:0] mem_r [MEM_DEPTH];

    // Storage array: cleared on reset, single-word write on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= {DATAWIDTH{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb_slave.sv
// APB completer: SETUP/ACCESS sequencing, fixed wait states, address and
// direction latch, registered PRDATA/PREADY in front of a byte memory.
module apb_slave
    import apb_pkg::*;
#(
    parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
    parameter int WAIT_STATES  = DEF_WAIT_STATES
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    apb_slave_if.slave    bus
);
    localparam int         IW   = index_width(MEM_DEPTH);
    localparam logic [3:0] WS_C = 4'(WAIT_STATES);

    apb_state_e           state_r;
    apb_state_e           state_nxt_s;
    logic [3:0]           cnt_r;
    logic [3:0]           cnt_nxt_s;
    logic [IW-1:0]        idx_r;
    logic                 pwrite_r;
    logic [DATAWIDTH-1:0] prdata_r;
    logic                 pready_r;
    logic                 pready_nxt_s;
    logic                 latch_s;
    logic                 commit_s;
    logic [DATAWIDTH-1:0] rdata_s;
    logic                 unused_addr_s;

    // Upper address bits only alias; fold them so they are consumed
    assign unused_addr_s = ^bus.PADDR;

    // FSM state register
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.PSELx && !bus.PENABLE) begin
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                if (!bus.PSELx) begin
                    state_nxt_s = IDLE;
                end else if (bus.PENABLE) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = SETUP;
                end
            end
            ACCESS: begin
                // Completion and abort both return to IDLE
                if (!bus.PSELx || !bus.PENABLE || pready_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: latch strobe, wait-count update, ready look-ahead, commit
    always_comb begin
        latch_s      = 1'b0;
        cnt_nxt_s    = cnt_r;
        pready_nxt_s = 1'b0;
        commit_s     = 1'b0;
        if ((state_r == IDLE) && (state_nxt_s == SETUP)) begin
            latch_s = 1'b1;
        end else begin
            latch_s = 1'b0;
        end
        if (state_nxt_s == SETUP) begin
            cnt_nxt_s = 4'd0;
        end else if ((state_r == ACCESS) && (cnt_r < WS_C)) begin
            cnt_nxt_s = cnt_r + 4'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        // PREADY is registered, so it is predicted from next state and count
        if ((state_nxt_s == ACCESS) && (cnt_nxt_s == WS_C)) begin
            pready_nxt_s = 1'b1;
        end else begin
            pready_nxt_s = 1'b0;
        end
        if ((state_r == ACCESS) && pready_r && bus.PSELx && bus.PENABLE && pwrite_r) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Wait counter and PREADY register
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            cnt_r    <= 4'd0;
            pready_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            pready_r <= pready_nxt_s;
        end
    end

    // Transfer latch (index, direction) and read-data capture on SETUP entry
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            idx_r    <= {IW{1'b0}};
            pwrite_r <= 1'b0;
            prdata_r <= {DATAWIDTH{1'b0}};
        end else if (latch_s) begin
            idx_r    <= bus.PADDR[IW-1:0];
            pwrite_r <= bus.PWRITE;
            if (!bus.PWRITE) begin
                prdata_r <= rdata_s;
            end
        end
    end

    apb_slave_mem #(
        .DATAWIDTH (DATAWIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .IW        (IW)
    ) u_mem (
        .clk   (PCLK),
        .rst   (PRESETn),
        .we    (commit_s),
        .waddr (idx_r),
        .wdata (bus.PWDATA),
        .raddr (bus.PADDR[IW-1:0]),
        .rdata (rdata_s)
    );

    assign bus.PRDATA = prdata_r;
    assign bus.PREADY = pready_r;

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: a zero-wait and a two-wait instance sharing
// clock and reset, driven through their interfaces.
module tb_apb_slave;
    import apb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    apb_slave_if #(.ADDRESSWIDTH(32), .DATAWIDTH(8)) if0 ();
    apb_slave_if #(.ADDRESSWIDTH(32), .DATAWIDTH(8)) if2 ();

    apb_slave #(.ADDRESSWIDTH(32), .DATAWIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .PCLK (clk), .PRESETn (rst), .bus (if0.slave)
    );
    apb_slave #(.ADDRESSWIDTH(32), .DATAWIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .PCLK (clk), .PRESETn (rst), .bus (if2.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic e, input logic wr,
                         input logic [31:0] a, input logic [7:0] d);
        if (w == 0) begin
            if0.PSELx = s; if0.PENABLE = e; if0.PWRITE = wr; if0.PADDR = a; if0.PWDATA = d;
        end else begin
            if2.PSELx = s; if2.PENABLE = e; if2.PWRITE = wr; if2.PADDR = a; if2.PWDATA = d;
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? if0.PREADY : if2.PREADY;
    endfunction

    function automatic logic [7:0] rdat(input int w);
        return (w == 0) ? if0.PRDATA : if2.PRDATA;
    endfunction

    function automatic logic [7:0] memv(input int w, input logic [7:0] i);
        return (w == 0) ? u_dut0.u_mem.mem_r[i] : u_dut2.u_mem.mem_r[i];
    endfunction

    // Full transfer; waits = ACCESS cycles with PREADY low (20 = never ready)
    task automatic xfer(input int w, input logic wr, input logic [31:0] a, input logic [7:0] d,
                        input logic hold_en, output int waits, output logic [7:0] pre);
        drive(w, 1'b1, 1'b0, wr, a, d);
        @(posedge clk); #1;
        drive(w, 1'b1, 1'b1, wr, a, d);
        waits = 0;
        pre   = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (rdy(w)) begin
                pre = memv(w, a[7:0]);
                break;
            end
            waits++;
        end
        @(posedge clk); #1;
        drive(w, 1'b0, hold_en, 1'b0, 32'h0, 8'h00);
    endtask

    initial begin
        int         waits;
        int         bad;
        logic [7:0] pre;
        clk = 1'b0;
        rst = 1'b1;
        n_checks = 0;
        n_fail = 0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_prdata0", 32'(if0.PRDATA), 32'h00);
        check_eq("rst_pready0", 32'(if0.PREADY), 32'h0);
        check_eq("rst_pready2", 32'(if2.PREADY), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset contents read back as zero
        xfer(0, 1'b0, 32'h0000_0055, 8'h00, 1'b0, waits, pre);
        check_eq("rd_after_rst", 32'(if0.PRDATA), 32'h00);

        // Zero-wait write, read back, alias read
        xfer(0, 1'b1, 32'h0000_01AA, 8'hF0, 1'b0, waits, pre);
        check_eq("wr0_waits", 32'(waits), 32'd0);
        check_eq("wr0_precommit", 32'(pre), 32'h00);
        xfer(0, 1'b0, 32'h0000_01AA, 8'h00, 1'b0, waits, pre);
        check_eq("rd0_waits", 32'(waits), 32'd0);
        check_eq("rd_1aa", 32'(if0.PRDATA), 32'hF0);
        xfer(0, 1'b0, 32'h0000_00AA, 8'h00, 1'b0, waits, pre);
        check_eq("rd_alias_0aa", 32'(if0.PRDATA), 32'hF0);

        // PRDATA holds across a write; PENABLE held high after it starts nothing
        xfer(0, 1'b1, 32'h7000_0001, 8'h3C, 1'b1, waits, pre);
        check_eq("prdata_hold", 32'(if0.PRDATA), 32'hF0);
        if0.PWDATA = 8'h11;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (if0.PREADY !== 1'b0 || u_dut0.state_r != IDLE) bad++;
        end
        check_eq("en_hold_idle", 32'(bad), 32'd0);
        if0.PENABLE = 1'b0;
        check_eq("en_hold_mem_aa", 32'(memv(0, 8'hAA)), 32'hF0);
        check_eq("en_hold_mem_01", 32'(memv(0, 8'h01)), 32'h3C);

        // Two wait states
        xfer(2, 1'b1, 32'h0000_0010, 8'h5A, 1'b0, waits, pre);
        check_eq("wr2_waits", 32'(waits), 32'd2);
        check_eq("wr2_precommit", 32'(pre), 32'h00);
        check_eq("wr2_postcommit", 32'(memv(2, 8'h10)), 32'h5A);

        // Abort in second ACCESS cycle
        drive(2, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 8'h33);
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 8'h33);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 8'h33);
        @(negedge clk);
        check_eq("abort_pready_low", 32'(if2.PREADY), 32'h0);
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        @(negedge clk);
        check_eq("abort_idle", 32'(u_dut2.state_r == IDLE), 32'h1);
        check_eq("abort_pready", 32'(if2.PREADY), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_mem20", 32'(memv(2, 8'h20)), 32'h00);

        xfer(2, 1'b0, 32'h0000_0010, 8'h00, 1'b0, waits, pre);
        check_eq("rd2_waits", 32'(waits), 32'd2);
        check_eq("rd2_10", 32'(if2.PRDATA), 32'h5A);

        // Reset during ACCESS
        drive(2, 1'b1, 1'b0, 1'b1, 32'h0000_0030, 8'h77);
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b1, 1'b1, 32'h0000_0030, 8'h77);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("rstmid_pready", 32'(if2.PREADY), 32'h0);
        check_eq("rstmid_prdata", 32'(if2.PRDATA), 32'h00);
        check_eq("rstmid_mem30", 32'(memv(2, 8'h30)), 32'h00);
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        xfer(2, 1'b0, 32'h0000_0030, 8'h00, 1'b0, waits, pre);
        check_eq("rstmid_rd30", 32'(if2.PRDATA), 32'h00);
        xfer(0, 1'b0, 32'h0000_00AA, 8'h00, 1'b0, waits, pre);
        check_eq("rst_cleared_aa", 32'(if0.PRDATA), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
